// File: rtl/tweakfetch.sv
// tweakfetch: instruction fetch unit with a DEPTH-entry prefetch queue.
//
// Owns the PC and issues sequential reads to a synchronous instruction memory
// with one-cycle read latency. Returned words are queued together with the PC
// they were fetched from and handed to the decoder over a valid/take handshake.
// A redirect flushes the queue, kills the in-flight read and reloads the PC.
//
// Parameters:
//   WORDSIZE  instruction word width
//   ADDRW     instruction address width (PC wraps modulo 2^ADDRW)
//   DEPTH     prefetch queue entries (>= 2)
//   RESET_PC  PC value loaded by reset
//
// Ports:
//   CLK            clock, rising edge
//   RESET          asynchronous active-high reset
//   run            fetch enable
//   redirect       flush queue, drop in-flight read, load redirect_addr
//   redirect_addr  new PC on redirect
//   mem_rd         read strobe to instruction memory
//   mem_addr       read address (the PC)
//   mem_data       read data, valid the cycle after mem_rd
//   op_valid       queue head valid
//   op_data        queue head instruction word
//   op_pc          address of op_data
//   op_take        consumer accepts the head this cycle
//   level          queue occupancy
//
// Build option:
//   TWEAKFETCH_BYPASS_EN  when defined, a word returning into an empty queue is
//                         presented on op_* in the same cycle (1-cycle latency).

module tweakfetch #(
    parameter int unsigned      WORDSIZE = 32,
    parameter int unsigned      ADDRW    = 8,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [ADDRW-1:0] RESET_PC = '0
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       run,
    input  logic                       redirect,
    input  logic [ADDRW-1:0]           redirect_addr,
    output logic                       mem_rd,
    output logic [ADDRW-1:0]           mem_addr,
    input  logic [WORDSIZE-1:0]        mem_data,
    output logic                       op_valid,
    output logic [WORDSIZE-1:0]        op_data,
    output logic [ADDRW-1:0]           op_pc,
    input  logic                       op_take,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;

    logic [ADDRW-1:0]    pc_q, pc_d;
    logic [ADDRW-1:0]    if_pc_q;      // PC of the read currently in flight
    logic                inflight_q, inflight_d;
    ptr_t                rd_ptr_q, rd_ptr_d;
    ptr_t                wr_ptr_q, wr_ptr_d;
    logic [LvlW-1:0]     count_q, count_d;
    logic [WORDSIZE-1:0] data_q [DEPTH];
    logic [ADDRW-1:0]    tag_q  [DEPTH];

    logic            issue;
    logic            capture;
    logic            empty;
    logic            bypass;
    logic            take;
    logic            push;
    logic            pop;
    logic [LvlW:0]   credit_used;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // Slots already promised: queued words plus the word still in flight.
        // A pop in this cycle is deliberately not counted as a free slot.
        credit_used = {1'b0, count_q} + {{LvlW{1'b0}}, inflight_q};
        issue       = run & ~redirect & ~RESET & (credit_used < (LvlW + 1)'(DEPTH));

        capture = inflight_q & ~redirect;
        empty   = (count_q == '0);
`ifdef TWEAKFETCH_BYPASS_EN
        bypass  = capture & empty;
`else
        bypass  = 1'b0;
`endif

        op_valid = ~redirect & (~empty | bypass);
        op_data  = bypass ? mem_data : data_q[rd_ptr_q];
        op_pc    = bypass ? if_pc_q  : tag_q[rd_ptr_q];

        take = op_valid & op_take;
        pop  = take & ~empty;
        // A bypassed word that is consumed immediately never touches storage.
        push = capture & ~(bypass & take);
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = issue;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            pc_d     = redirect_addr;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (issue) begin
                if_pc_q <= pc_q;
            end
        end
    end

    // Storage is cleared on reset so op_data/op_pc read as zero afterwards.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= mem_data;
            tag_q[wr_ptr_q]  <= if_pc_q;
        end
    end

    assign mem_rd   = issue;
    assign mem_addr = pc_q;
    assign level    = count_q;

endmodule

// File: tb/tb_tweakfetch.sv
module tb_tweakfetch;

    localparam int WS    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

`ifdef TWEAKFETCH_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic          run;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [WS-1:0] mem_data;
    logic          op_valid;
    logic [WS-1:0] op_data;
    logic [AW-1:0] op_pc;
    logic          op_take;
    logic [LW-1:0] level;

    always #5 CLK = ~CLK;

    tweakfetch #(
        .WORDSIZE (WS),
        .ADDRW    (AW),
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .run           (run),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .op_valid      (op_valid),
        .op_data       (op_data),
        .op_pc         (op_pc),
        .op_take       (op_take),
        .level         (level)
    );

    // Synchronous memory: word at address a is 0x100 + a; idle cycles return noise.
    always @(posedge CLK) begin
        mem_data <= mem_rd ? (32'h100 + 32'(mem_addr)) : $urandom;
    end

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [WS-1:0] data;
    } ent_t;

    // Reference model: a plain FIFO of fetched words plus the pending read.
    ent_t          mq[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_if_pc;
    bit            m_inflight;

    ent_t seen[$];
    bit   collect;

    int total = 0;
    int bad   = 0;

    function automatic logic [WS-1:0] word_at(logic [AW-1:0] a);
        return 32'h100 + 32'(a);
    endfunction

    task automatic m_reset();
        mq.delete();
        m_pc       = 8'h00;
        m_if_pc    = '0;
        m_inflight = 1'b0;
    endtask

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        bit   e_capt;
        bit   e_rd;
        bit   e_valid;
        bit   was_empty;
        bit   take;
        ent_t e_head;
        @(negedge CLK);
        if (RESET) m_reset();
        e_capt  = m_inflight && !redirect && !RESET;
        e_rd    = run && !redirect && !RESET && ((mq.size() + int'(m_inflight)) < DEPTH);
        e_valid = 1'b0;
        e_head  = '0;
        if (!redirect && !RESET) begin
            if (mq.size() > 0) begin
                e_valid = 1'b1;
                e_head  = mq[0];
            end else if (Byp && e_capt) begin
                e_valid = 1'b1;
                e_head  = {m_if_pc, word_at(m_if_pc)};
            end
        end
        chk("mem_rd", 64'(mem_rd), 64'(e_rd));
        chk("mem_addr", 64'(mem_addr), 64'(m_pc));
        chk("level", 64'(level), 64'(mq.size()));
        chk("op_valid", 64'(op_valid), 64'(e_valid));
        if (e_valid) begin
            chk("op_pc", 64'(op_pc), 64'(e_head.pc));
            chk("op_data", 64'(op_data), 64'(e_head.data));
        end
        if (RESET) begin
            chk("rst_op_pc", 64'(op_pc), 64'(0));
            chk("rst_op_data", 64'(op_data), 64'(0));
        end
        if (collect && op_valid) seen.push_back({op_pc, op_data});
        @(posedge CLK);
        if (RESET) begin
            m_reset();
        end else if (redirect) begin
            mq.delete();
            m_inflight = 1'b0;
            m_pc       = redirect_addr;
        end else begin
            was_empty = (mq.size() == 0);
            take      = e_valid && op_take;
            if (take && !was_empty) void'(mq.pop_front());
            if (e_capt && !(Byp && was_empty && take)) mq.push_back({m_if_pc, word_at(m_if_pc)});
            if (e_rd) begin
                m_if_pc = m_pc;
                m_pc    = m_pc + 8'd1;
            end
            m_inflight = e_rd;
        end
        #1;
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_redirect(logic [AW-1:0] a);
        redirect      = 1'b1;
        redirect_addr = a;
        cycle();
        redirect      = 1'b0;
    endtask

    // Compare the first n collected ops against a sequential run starting at pc0.
    task automatic check_seq(string tag, logic [AW-1:0] pc0, int n);
        logic [AW-1:0] p;
        chk({tag, "_count"}, 64'(seen.size() >= n), 64'(1));
        p = pc0;
        for (int i = 0; i < n && i < seen.size(); i++) begin
            chk({tag, "_pc"}, 64'(seen[i].pc), 64'(p));
            chk({tag, "_data"}, 64'(seen[i].data), 64'(word_at(p)));
            p = p + 8'd1;
        end
        seen.delete();
    endtask

    initial begin
        RESET         = 1'b1;
        run           = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        op_take       = 1'b0;
        collect       = 1'b0;
        m_reset();

        // Reset, then idle with run low.
        cycles(2);
        RESET = 1'b0;
        cycles(5);

        // Streaming with the consumer always ready.
        run     = 1'b1;
        op_take = 1'b1;
        collect = 1'b1;
        cycles(16);
        collect = 1'b0;
        check_seq("stream", 8'h00, 8);

        // Backpressure: queue fills, reads stop; one take frees exactly one slot.
        op_take = 1'b0;
        cycles(8);
        chk("bp_level", 64'(level), 64'(4));
        chk("bp_rd", 64'(mem_rd), 64'(0));
        op_take = 1'b1;
        cycle();
        op_take = 1'b0;
        cycle();

        // Redirect with three queued words and a read in flight.
        chk("pre_redir_level", 64'(level), 64'(3));
        do_redirect(8'h40);
        chk("redir_level", 64'(level), 64'(0));
        chk("redir_addr", 64'(mem_addr), 64'(8'h40));
        op_take = 1'b1;
        collect = 1'b1;
        cycles(8);
        collect = 1'b0;
        check_seq("redir", 8'h40, 4);

        // Address wrap across the top of the PC range.
        do_redirect(8'hFE);
        collect = 1'b1;
        cycles(8);
        collect = 1'b0;
        check_seq("wrap", 8'hFE, 4);

        // Asynchronous reset with two queued words and a read in flight.
        op_take = 1'b0;
        do_redirect(8'h10);
        cycles(3);
        chk("pre_rst_level", 64'(level), 64'(2));
        RESET = 1'b1;
        #1;
        chk("async_level", 64'(level), 64'(0));
        chk("async_valid", 64'(op_valid), 64'(0));
        chk("async_rd", 64'(mem_rd), 64'(0));
        chk("async_addr", 64'(mem_addr), 64'(0));
        cycles(2);
        RESET   = 1'b0;
        op_take = 1'b1;
        collect = 1'b1;
        cycles(8);
        collect = 1'b0;
        check_seq("post_rst", 8'h00, 4);

        // Random mix of run, take and redirect.
        for (int i = 0; i < 400; i++) begin
            run           = ($urandom % 8) != 0;
            op_take       = ($urandom % 3) != 0;
            redirect      = ($urandom % 20) == 0;
            redirect_addr = 8'($urandom);
            cycle();
        end
        redirect = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tweakfetch.md
# tweakfetch

Parametrised instruction fetch unit with a prefetch queue, the successor to the fixed fetch path (free-running address counter plus 8-word memory) in `tweakpu`. It owns the program counter and issues sequential reads to a synchronous instruction memory with one-cycle read latency. Returned words are buffered in a DEPTH-entry queue, and each word is tagged with its PC. The unit supports redirect/flush for jumps and a ready/valid handshake toward the decoder (`tweakdec`).

## Interface
- `WORDSIZE`, 32, instruction word width
- `ADDRW`, 8, instruction address width; PC wraps modulo 2^ADDRW
- `DEPTH`, 4, prefetch queue entries (≥2; ≥3 needed for 1 op/cycle sustained)
- `RESET_PC`, 0, PC value loaded by reset
- `CLK`  in  1  clock; all state changes on rising edge
- `RESET`  in  1  asynchronous, active-high reset
- `run`  in  1  fetch enable; when low, no new reads issue
- `redirect`  in  1  flush queue, discard in-flight read, load PC
- `redirect_addr`  in  ADDRW  new PC on redirect
- `mem_rd`  out  1  read strobe to instruction memory
- `mem_addr`  out  ADDRW  read address (equals PC)
- `mem_data`  in  WORDSIZE  read data, valid the cycle after `mem_rd`
- `op_valid`  out  1  queue head valid
- `op_data`  out  WORDSIZE  queue head instruction word
- `op_pc`  out  ADDRW  address of `op_data`
- `op_take`  in  1  consumer accepts head this cycle
- `level`  out  $clog2(DEPTH+1)  current queue occupancy

## Operation
- State: PC, `inflight` flag (read issued last cycle, not killed), circular queue (rd/wr pointers, count), plus a PC tag per entry.
- Issue: `mem_rd` = `run` & !`redirect` & (`level` + `inflight` < DEPTH). A pop in the same cycle is not credited. `mem_addr` = PC. On issue, PC ← PC+1, wrapping from 2^ADDRW−1 to 0.
- Capture: if `inflight` and no `redirect`, then `mem_data` and its PC tag are pushed into the queue. The queue never overflows because of the credit rule.
- Pop: `op_valid` & `op_take` advances the read pointer. If `op_take` is asserted while `op_valid` is low, it is ignored.
- Simultaneous push and pop: `level` is unchanged and both pointers advance.
- Redirect (cycle N):
  - `op_valid` is forced to 0 and `op_take` is ignored.
  - `mem_rd` = 0.
  - Any response arriving in cycle N is dropped.
  - At the edge ending cycle N: queue cleared, `inflight` ← 0, PC ← `redirect_addr`.
  - Cycle N+1: `mem_rd` with `mem_addr` = `redirect_addr` (if `run` is high).
- `run` low: reads stop. A read already in flight still completes and is queued. Queue contents are held.
- Outputs come from queue storage, so `op_data`/`op_pc` are stable while `op_valid` is high and `op_take` is low.

## Timing
- Reset values:
  - `mem_rd`=0, `mem_addr`=RESET_PC, `op_valid`=0, `level`=0
  - `op_data`/`op_pc` = 0
  - `inflight`=0, pointers=0
- Latency, without bypass:
  - `mem_rd` in cycle N → word in queue at the end of N+1 → `op_valid` in N+2.
- Throughput:
  - 1 op/cycle for DEPTH≥3 with `op_take` held high.
  - For DEPTH=2, issue alternates cycles.
- Asynchronous `RESET` mid-operation clears all state immediately. A memory response arriving in the first cycle after release is discarded, because `inflight`=0.
- Redirect takes priority over issue, capture and pop in the same cycle.

## Configuration
- `TWEAKFETCH_BYPASS_EN` defined: when the queue is empty and a response is being captured, `op_valid`/`op_data`/`op_pc` are driven directly from `mem_data`/tag in cycle N+1.
  - If `op_take` is high, the word is not written into the queue.
  - Otherwise it is pushed as normal.
  - Fetch-to-op latency becomes 1 cycle. Redirect still forces `op_valid`=0.
- Undefined: no bypass. `op_valid` only reflects queue occupancy, and latency is 2 cycles.

## Test plan
- Reset/idle: RESET=1 then 0, `run`=0 for 5 cycles → `mem_rd`=0, `op_valid`=0, `level`=0, `mem_addr`=0.
- Streaming: memory returns `mem_data`=addr+0x100, `run`=1, `op_take`=1, DEPTH=4 → ops 0x100,0x101,… with `op_pc` 0,1,… one per cycle, first `op_valid` 2 cycles after first `mem_rd` (1 with bypass).
- Backpressure: `op_take`=0 → `level` rises to 4 and `mem_rd` stays low; then take one → exactly one new read issues, and order is preserved with no loss or duplication.
- Redirect: `redirect`=1, `redirect_addr`=0x40 while the queue holds 3 words and a read is in flight → next cycle `level`=0 and `mem_addr`=0x40; the next op has `op_pc`=0x40, and the stale in-flight word never appears.
- Wrap: ADDRW=4, redirect to 0xE, stream 4 ops → `op_pc` sequence 0xE,0xF,0x0,0x1.
- Mid-operation reset: assert RESET while the queue has 2 entries and a read is in flight → outputs go to reset values immediately; after release, the first op has `op_pc`=RESET_PC.
